// File: rtl/ud_cnt_ctrl.sv
// Button command sequencer for the up/down counter: synchronises and debounces
// the raw buttons, then issues one-clk en/up/down pulses with tick-paced auto-repeat.
module ud_cnt_ctrl #(
   parameter int DB_TICKS = 4,
   parameter int RPT_DLY  = 50,
   parameter int RPT_PER  = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_hold,
   output logic en,
   output logic up,
   output logic down,
   output logic paused,
   output logic conflict
);

   localparam int TMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int CW   = $clog2(DB_TICKS + 1);

   localparam logic [CW-1:0] DB_LAST_V = CW'(DB_TICKS - 1);
   localparam logic [TW-1:0] DLY_V     = TW'(RPT_DLY);
   localparam logic [TW-1:0] PER_V     = TW'(RPT_PER);
   localparam logic [TW-1:0] TMAX_V    = TW'(TMAX);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RPT = 2'd1,
      REPEAT   = 2'd2,
      CONFLICT = 2'd3
   } state_e;

   // Bit order in all 3-bit vectors: [0]=up, [1]=down, [2]=hold.
   logic [2:0]          sync1_q, sync2_q;
   logic [2:0]          db_lvl_q, db_lvl_d;
   logic [2:0][CW-1:0]  db_cnt_q, db_cnt_d;
   logic [2:0]          press_s;

   state_e              state_q, state_d;
   logic                dir_q, dir_d;
   logic [TW-1:0]       tmr_q, tmr_d;
   logic [TW-1:0]       tmr_inc_s;
   logic [TW-1:0]       tmr_lim_s;
   logic                held_s, other_s, pulse_s;
   logic                paused_q, paused_d;
   logic                en_q, en_d, up_q, up_d, down_q, down_d, conflict_q, conflict_d;

   // Two-flop synchroniser for the asynchronous buttons.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= {btn_hold, btn_down, btn_up};
         sync2_q <= sync1_q;
      end
   end

   // Debounce counters: a level flips only after DB_TICKS consecutive differing samples.
   always_comb begin
      db_lvl_d = db_lvl_q;
      db_cnt_d = db_cnt_q;
      press_s  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (tick) begin
            if (sync2_q[i] != db_lvl_q[i]) begin
               if (db_cnt_q[i] == DB_LAST_V) begin
                  db_lvl_d[i] = sync2_q[i];
                  db_cnt_d[i] = '0;
                  press_s[i]  = sync2_q[i];
               end else begin
                  db_cnt_d[i] = db_cnt_q[i] + CW'(1);
               end
            end else begin
               db_cnt_d[i] = '0;
            end
         end else begin
            db_cnt_d[i] = db_cnt_q[i];
         end
      end
   end

   // Sequencer next state; release and conflict are judged on this tick's new levels.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      tmr_d     = tmr_q;
      paused_d  = paused_q;
      pulse_s   = 1'b0;
      held_s    = dir_q ? db_lvl_d[0] : db_lvl_d[1];
      other_s   = dir_q ? db_lvl_d[1] : db_lvl_d[0];
      tmr_inc_s = (tmr_q == TMAX_V) ? tmr_q : tmr_q + TW'(1);
      tmr_lim_s = (state_q == WAIT_RPT) ? DLY_V : PER_V;
      if (!tick) begin
         state_d = state_q;
      end else if (press_s[2]) begin
         paused_d = ~paused_q;
         if (!paused_q) begin
            state_d = IDLE;
            tmr_d   = '0;
         end else begin
            state_d = state_q;
         end
      end else if (paused_q) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (press_s[0] && press_s[1]) begin
                  state_d = CONFLICT;
               end else if (press_s[0] || press_s[1]) begin
                  pulse_s = 1'b1;
                  dir_d   = press_s[0];
                  tmr_d   = '0;
                  state_d = WAIT_RPT;
               end else begin
                  state_d = IDLE;
               end
            end
            WAIT_RPT, REPEAT: begin
               if (!held_s) begin
                  state_d = IDLE;
               end else if (other_s) begin
                  state_d = CONFLICT;
               end else if (tmr_inc_s == tmr_lim_s) begin
                  pulse_s = 1'b1;
                  tmr_d   = '0;
                  state_d = REPEAT;
               end else begin
                  tmr_d   = tmr_inc_s;
               end
            end
            CONFLICT: begin
               if (db_lvl_d[1:0] == 2'b00) begin
                  state_d = IDLE;
               end else begin
                  state_d = CONFLICT;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      en_d       = pulse_s;
      up_d       = pulse_s & dir_d;
      down_d     = pulse_s & ~dir_d;
      conflict_d = (state_d == CONFLICT);
   end

   // State, timers and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_lvl_q   <= 3'b000;
         db_cnt_q   <= '0;
         state_q    <= IDLE;
         dir_q      <= 1'b0;
         tmr_q      <= '0;
         paused_q   <= 1'b0;
         en_q       <= 1'b0;
         up_q       <= 1'b0;
         down_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         db_lvl_q   <= db_lvl_d;
         db_cnt_q   <= db_cnt_d;
         state_q    <= state_d;
         dir_q      <= dir_d;
         tmr_q      <= tmr_d;
         paused_q   <= paused_d;
         en_q       <= en_d;
         up_q       <= up_d;
         down_q     <= down_d;
         conflict_q <= conflict_d;
      end
   end

   assign en       = en_q;
   assign up       = up_q;
   assign down     = down_q;
   assign paused   = paused_q;
   assign conflict = conflict_q;

endmodule
